// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-port synchronous memory
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is data-first priority.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_valid,
  output logic                     if_stall,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [ADDRESS_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]    dm_wdata,
  output logic [DATA_WIDTH-1:0]    dm_rdata,
  output logic                     dm_valid,
  output logic                     dm_stall,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     owner_q, owner_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     if_valid_q, if_valid_d;
  logic                     dm_valid_q, dm_valid_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]    dm_rdata_q, dm_rdata_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                     grant_dm;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_grant_q: 1 = data was granted last; a lone requester ignores it
  logic last_grant_q;
  assign grant_dm = dm_req & (~if_req | ~last_grant_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= 1'b0;
    end else if (state_q == S_IDLE && (if_req || dm_req)) begin
      last_grant_q <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        // The memory-side registers double as the latched transaction.
        if (if_req || dm_req) begin
          state_d     = S_ISSUE;
          owner_d     = grant_dm;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dm & dm_we;
          mem_addr_d  = grant_dm ? dm_addr : if_addr;
          mem_wdata_d = grant_dm ? dm_wdata : mem_wdata_q;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) begin
            dm_rdata_d = mem_rdata;
            dm_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dm_valid", dm_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] memval;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  logic [31:0] mem [256];
  logic [31:0] exp_ifr, exp_dmr;
  logic [7:0]  exp_maddr;
  logic        busy, owner, twe, last_grant, if_act, dm_act, if_vprev, dm_vprev;
  logic        e_en, e_ifv, e_dmv, w;
  logic [7:0]  taddr;
  logic [31:0] twdata;
  int          ts;

  initial begin
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    vecs[0] = '{1'b0, 1'b0, 8'h04, 32'h0,        32'h00500093, 1'b0, 32'h00500093};
    vecs[1] = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 32'h0,        32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 32'h00000000, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};

    do_reset();
    exp_ifr = '0; exp_dmr = '0;

    // single transactions from the table
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c <= 3 + L; c++) begin
        @(negedge clk);
        if_req   = !vecs[i].is_dm && c <= 2 + L;
        dm_req   =  vecs[i].is_dm && c <= 2 + L;
        if_addr  = vecs[i].addr;
        dm_addr  = vecs[i].addr;
        dm_we    = vecs[i].we;
        dm_wdata = vecs[i].wdata;
        mem_rdata = (c == 1 + L) ? vecs[i].memval : (32'hBAD00000 | c);
        #1;
        if (c == 2 + L) begin
          if (vecs[i].is_dm) exp_dmr = vecs[i].exp_rdata;
          else               exp_ifr = vecs[i].exp_rdata;
        end
        chk($sformatf("vec%0d_c%0d_mem_en", i, c), mem_en, c == 1);
        chk($sformatf("vec%0d_c%0d_mem_we", i, c), mem_we, (c == 1) ? vecs[i].exp_we : 1'b0);
        if (c == 1) chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].addr);
        if (c == 1 && vecs[i].exp_we) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
        chk($sformatf("vec%0d_c%0d_if_valid", i, c), if_valid, !vecs[i].is_dm && c == 2 + L);
        chk($sformatf("vec%0d_c%0d_dm_valid", i, c), dm_valid,  vecs[i].is_dm && c == 2 + L);
        chk($sformatf("vec%0d_c%0d_if_rdata", i, c), if_rdata, exp_ifr);
        chk($sformatf("vec%0d_c%0d_dm_rdata", i, c), dm_rdata, exp_dmr);
        chk($sformatf("vec%0d_c%0d_if_stall", i, c), if_stall, if_req && c != 2 + L);
        chk($sformatf("vec%0d_c%0d_dm_stall", i, c), dm_stall, dm_req && c != 2 + L);
      end
    end

    // contention: both requests held for 20 cycles
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      if_addr = 8'h40; dm_addr = 8'h80;
      mem_rdata = $urandom;
      #1;
      chk($sformatf("cont_c%0d_mem_en", c), mem_en, (c % 5) == 1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      chk($sformatf("cont_c%0d_dm_valid", c), dm_valid, (c % 10) == 4);
      chk($sformatf("cont_c%0d_if_valid", c), if_valid, (c % 10) == 9);
      chk($sformatf("cont_c%0d_if_stall", c), if_stall, (c % 10) != 9);
      chk($sformatf("cont_c%0d_dm_stall", c), dm_stall, (c % 10) != 4);
`else
      chk($sformatf("cont_c%0d_dm_valid", c), dm_valid, (c % 5) == 4);
      chk($sformatf("cont_c%0d_if_valid", c), if_valid, 0);
      chk($sformatf("cont_c%0d_if_stall", c), if_stall, 1);
      chk($sformatf("cont_c%0d_dm_stall", c), dm_stall, (c % 5) != 4);
`endif
    end

    // reset during the first WAIT cycle of a fetch
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if_req = (c <= 7); dm_req = 1'b0; if_addr = 8'h08;
      rst = (c == 2) ? 1'b0 : 1'b1;
      mem_rdata = (c == 6) ? 32'h13579BDF : (32'hBAD10000 | c);
      #1;
      chk($sformatf("rstmid_c%0d_mem_en", c), mem_en, c == 1 || c == 4);
      chk($sformatf("rstmid_c%0d_if_valid", c), if_valid, c == 7);
      chk($sformatf("rstmid_c%0d_if_stall", c), if_stall, c < 7);
      if (c == 3) chk("rstmid_if_rdata_cleared", if_rdata, 0);
      if (c == 4) chk("rstmid_mem_addr", mem_addr, 8'h08);
      if (c == 7) chk("rstmid_if_rdata", if_rdata, 32'h13579BDF);
    end

    // randomized traffic against a transaction-timeline model
    do_reset();
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    busy = 0; owner = 0; twe = 0; taddr = '0; twdata = '0; ts = 0; last_grant = 0;
    exp_ifr = '0; exp_dmr = '0; exp_maddr = '0;
    if_act = 0; dm_act = 0; if_vprev = 0; dm_vprev = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      e_en  = busy && c == ts + 1;
      e_ifv = busy && c == ts + 2 + L && !owner;
      e_dmv = busy && c == ts + 2 + L &&  owner;
      if (if_vprev) begin
        if_act = 1'($urandom_range(0, 1));
        if (if_act) if_addr = 8'($urandom);
      end else if (!if_act && $urandom_range(0, 3) == 0) begin
        if_act = 1; if_addr = 8'($urandom);
      end
      if (dm_vprev) begin
        dm_act = 1'($urandom_range(0, 1));
        if (dm_act) begin dm_addr = 8'($urandom); dm_we = 1'($urandom); dm_wdata = $urandom; end
      end else if (!dm_act && $urandom_range(0, 3) == 0) begin
        dm_act = 1; dm_addr = 8'($urandom); dm_we = 1'($urandom); dm_wdata = $urandom;
      end
      if_req = if_act; dm_req = dm_act;
      mem_rdata = (busy && c == ts + 1 + L) ? mem[taddr] : $urandom;
      #1;
      if (e_en) exp_maddr = taddr;
      chk("rnd_mem_en", mem_en, e_en);
      chk("rnd_mem_we", mem_we, e_en && twe);
      chk("rnd_mem_addr", mem_addr, exp_maddr);
      if (e_en && twe) chk("rnd_mem_wdata", mem_wdata, twdata);
      chk("rnd_if_valid", if_valid, e_ifv);
      chk("rnd_dm_valid", dm_valid, e_dmv);
      chk("rnd_if_rdata", if_rdata, exp_ifr);
      chk("rnd_dm_rdata", dm_rdata, exp_dmr);
      chk("rnd_if_stall", if_stall, if_req && !e_ifv);
      chk("rnd_dm_stall", dm_stall, dm_req && !e_dmv);
      if_vprev = e_ifv; dm_vprev = e_dmv;
      if (busy) begin
        if (c == ts + 1 && twe) mem[taddr] = twdata;
        if (c == ts + 1 + L) begin
          if (owner) exp_dmr = mem[taddr];
          else       exp_ifr = mem[taddr];
        end
        if (c == ts + 2 + L) busy = 0;
      end else if (if_req || dm_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        w = dm_req && (!if_req || !last_grant);
`else
        w = dm_req;
`endif
        last_grant = w;
        busy = 1; ts = c; owner = w;
        taddr  = w ? dm_addr : if_addr;
        twe    = w ? dm_we : 1'b0;
        twdata = dm_wdata;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
